// File: rtl/fp16_add_ctrl.sv
// fp16_add_ctrl: multi-cycle FP16 add sequencer.
// Loads the operand bank, then aligns, adds, normalizes and packs the sum.
module fp16_add_ctrl #(
    parameter int ALIGN_MAX = 12
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] maior,
    input  logic [15:0] menor,
    output logic        hab_escrita,
    output logic        busy,
    output logic        done,
    output logic [15:0] resultado,
    output logic        overflow,
    output logic        zero
);

    localparam logic [4:0] AMAX = 5'(ALIGN_MAX);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CAPTURE, S_ALIGN, S_ADD, S_NORM, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        sgn_m_q, sgn_m_d;
    logic        sgn_n_q, sgn_n_d;
    logic        sgn_r_q, sgn_r_d;
    logic        spec_q, spec_d;
    logic [10:0] mant_m_q, mant_m_d;
    logic [10:0] mant_n_q, mant_n_d;
    logic [4:0]  exp_r_q, exp_r_d;
    logic [4:0]  dist_q, dist_d;
    logic [11:0] sum_q, sum_d;
    logic [15:0] res_q, res_d;
    logic        ovf_q, ovf_d;
    logic        zero_q, zero_d;
    logic [4:0]  exp_diff;

    assign exp_diff    = maior[14:10] - menor[14:10];
    assign hab_escrita = (state_q == S_LOAD);
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign resultado   = res_q;
    assign overflow    = ovf_q;
    assign zero        = zero_q;

    // Register all sequencer and datapath state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            sgn_m_q  <= 1'b0;
            sgn_n_q  <= 1'b0;
            sgn_r_q  <= 1'b0;
            spec_q   <= 1'b0;
            mant_m_q <= '0;
            mant_n_q <= '0;
            exp_r_q  <= '0;
            dist_q   <= '0;
            sum_q    <= '0;
            res_q    <= '0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sgn_m_q  <= sgn_m_d;
            sgn_n_q  <= sgn_n_d;
            sgn_r_q  <= sgn_r_d;
            spec_q   <= spec_d;
            mant_m_q <= mant_m_d;
            mant_n_q <= mant_n_d;
            exp_r_q  <= exp_r_d;
            dist_q   <= dist_d;
            sum_q    <= sum_d;
            res_q    <= res_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    // Next-state and datapath updates, one step per state.
    always_comb begin
        state_d  = state_q;
        sgn_m_d  = sgn_m_q;
        sgn_n_d  = sgn_n_q;
        sgn_r_d  = sgn_r_q;
        spec_d   = spec_q;
        mant_m_d = mant_m_q;
        mant_n_d = mant_n_q;
        exp_r_d  = exp_r_q;
        dist_d   = dist_q;
        sum_d    = sum_q;
        res_d    = res_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                sgn_m_d  = maior[15];
                sgn_n_d  = menor[15];
                mant_m_d = (maior[14:10] != 5'd0) ?
                           {1'b1, maior[9:0]} : 11'd0;
                mant_n_d = (menor[14:10] != 5'd0) ?
                           {1'b1, menor[9:0]} : 11'd0;
                exp_r_d  = maior[14:10];
                dist_d   = (exp_diff >= AMAX) ? AMAX : exp_diff;
                // Infinity is decided one cycle later, in ALIGN.
                spec_d   = (maior[14:10] == 5'd31) ||
                           (menor[14:10] == 5'd31);
                sgn_r_d  = (maior[14:10] == 5'd31) ?
                           maior[15] : menor[15];
                state_d  = S_ALIGN;
            end
            S_ALIGN: begin
                if (spec_q) begin
                    res_d   = {sgn_r_q, 15'h7C00};
                    ovf_d   = 1'b1;
                    zero_d  = 1'b0;
                    state_d = S_DONE;
                end else if (dist_q == 5'd0) begin
                    state_d = S_ADD;
                end else begin
                    mant_n_d = mant_n_q >> 1;
                    dist_d   = dist_q - 5'd1;
                end
            end
            S_ADD: begin
                if (sgn_m_q == sgn_n_q) begin
                    sum_d   = {1'b0, mant_m_q} + {1'b0, mant_n_q};
                    sgn_r_d = sgn_m_q;
                end else if (mant_m_q >= mant_n_q) begin
                    sum_d   = {1'b0, mant_m_q - mant_n_q};
                    sgn_r_d = sgn_m_q;
                end else begin
                    sum_d   = {1'b0, mant_n_q - mant_m_q};
                    sgn_r_d = sgn_n_q;
                end
                state_d = S_NORM;
            end
            S_NORM: begin
                if (sum_q == 12'd0) begin
                    res_d   = 16'h0000;
                    ovf_d   = 1'b0;
                    zero_d  = 1'b1;
                    state_d = S_DONE;
                end else if (sum_q[11]) begin
                    sum_d   = sum_q >> 1;
                    exp_r_d = exp_r_q + 5'd1;
                    zero_d  = 1'b0;
                    state_d = S_DONE;
                    if (exp_r_q == 5'd30) begin
                        res_d = {sgn_r_q, 15'h7C00};
                        ovf_d = 1'b1;
                    end else begin
                        res_d = {sgn_r_q, exp_r_q + 5'd1, sum_q[10:1]};
                        ovf_d = 1'b0;
                    end
                end else if (sum_q[10]) begin
                    res_d   = {sgn_r_q, exp_r_q, sum_q[9:0]};
                    ovf_d   = 1'b0;
                    zero_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    sum_d   = sum_q << 1;
                    exp_r_d = exp_r_q - 5'd1;
                    // Underflow flushes to +0 rather than denormalizing.
                    if (exp_r_q == 5'd1) begin
                        res_d   = 16'h0000;
                        ovf_d   = 1'b0;
                        zero_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
